axi4_mem_master: RTL and testbench
==================================

// Module: axi4_mem_master
// PURPOSE
//  Bridges a std_mem request/response pair onto an AXI4 master port: the initiator end of the AXI link whose
//  responder converts AXI back into std_mem (supervisor path). Lets a gecko core or DMA engine reach AXI slaves.
//  Single outstanding transaction, single-beat (LEN=0) 32-bit accesses; reads return data on mem_response.
// PARAMETERS
//  AXI_ID_WIDTH    1   width of ARID/AWID/RID/BID
//  AXI_ADDR_WIDTH  32  AXI byte-address width
//  AXI_DATA_WIDTH  32  AXI data width; must equal MEM_DATA_WIDTH (elaboration error otherwise)
//  AXI_USER_WIDTH  1   width of user fields; driven 0
//  MEM_ADDR_WIDTH  32  std_mem word-address width
//  MEM_DATA_WIDTH  32  std_mem data width
//  AXI_ID          0   constant ID driven on ARID/AWID
// PORTS
//  clk           in   1      clock; all logic on rising edge
//  rst           in   1      synchronous, active-high reset
//  mem_request   in   intf   std_mem_intf.in: valid/ready, read_write(1=write), addr(MEM_ADDR_WIDTH), data, write_enable(MEM_DATA_WIDTH/8)
//  mem_response  out  intf   std_mem_intf.out: valid/ready, data (read data), addr echoed
//  axi_ar        out  intf   axi4_ar_intf.out
//  axi_aw        out  intf   axi4_aw_intf.out
//  axi_w         out  intf   axi4_w_intf.out
//  axi_r         in   intf   axi4_r_intf.in
//  axi_b         in   intf   axi4_b_intf.in
//  error_flag    out  1      sticky: set on any RRESP/BRESP != OKAY; cleared only by rst
// BEHAVIOUR
//  Reset: state IDLE; ARVALID/AWVALID/WVALID/mem_response.valid = 0; RREADY/BREADY = 0; error_flag = 0.
//  Reset mid-transaction abandons it; rst must be common with the AXI slave.
//  FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP.
//  IDLE: mem_request.ready = 1 (only state where it is 1). On valid&ready latch addr/data/strobe/rw:
//        read -> RD_ADDR, write -> WR_REQ. Registered outputs: ARVALID/AWVALID rise the cycle after accept.
//  RD_ADDR: ARVALID=1, ARADDR={addr,2'b00} truncated/zero-extended to AXI_ADDR_WIDTH; ARLEN=0, ARSIZE=2,
//        ARBURST=INCR, ARID=AXI_ID, ARPROT/CACHE/LOCK/QOS/REGION=0. ARVALID held stable until ARREADY -> RD_DATA.
//  RD_DATA: RREADY=1; on RVALID capture RDATA into response register, OR (RRESP!=0) into error_flag -> RESP.
//        RLAST ignored (always single beat). RID not checked.
//  RESP: mem_response.valid=1, data held stable until mem_response.ready -> IDLE (next accept earliest next cycle).
//  WR_REQ: AWVALID and WVALID asserted together; each drops independently on its own handshake (tracked by
//        aw_done/w_done flags, accepted same cycle or either order). WSTRB=write_enable, WLAST=1.
//        When both done (incl. same cycle) -> WR_RESP.
//  WR_RESP: BREADY=1; on BVALID OR (BRESP!=0) into error_flag -> IDLE. No mem_response for writes.
//  Write with write_enable=0 still issues full AXI write with WSTRB=0.
//  Latency (zero-wait slave): read accept->ARVALID 1 cycle; RVALID->mem_response.valid 1 cycle.
//  Min read turnaround 4 cycles; min write 3 cycles. Throughput: one transaction at a time, never overlapped.
//  Valids never drop without handshake; payloads stable while valid high (AXI and std_mem rules).
// TESTING
//  1 Read: req addr=0x0000_0040 rw=0; slave RDATA=0xDEAD_BEEF OKAY -> ARADDR=0x100, ARLEN=0, one response data=0xDEAD_BEEF.
//  2 Write: addr=0x10 data=0x1234_5678 we=4'b0011 -> AWADDR=0x40, WDATA=0x1234_5678, WSTRB=0011, WLAST=1; no mem_response.
//  3 AW/W skew: AWREADY 3 cycles after WREADY, then same-cycle both -> exactly one AW and one W beat each; BREADY only after both.
//  4 Backpressure: ARREADY low 5 cycles, mem_response.ready low 4 cycles -> ARVALID/ARADDR and response data held;
//    mem_request.ready=0 throughout.
//  5 Error: RRESP=SLVERR on read -> data still returned, error_flag=1 and stays 1 across later OKAY transactions until rst.
//  6 Reset in RD_DATA: rst one cycle -> all valids 0, state IDLE, mem_request.ready=1 the cycle after rst deasserts.

Source files
------------

// File: rtl/axi4_mem_master.sv
// std_mem request/response to AXI4 master bridge: one outstanding single-beat access at a time.
// Reads return data on mem_response; writes complete silently on BRESP. Any non-OKAY response sets error_flag.
module axi4_mem_master #(
  parameter int          AXI_ID_WIDTH   = 1,
  parameter int          AXI_ADDR_WIDTH = 32,
  parameter int          AXI_DATA_WIDTH = 32,
  parameter int          AXI_USER_WIDTH = 1,
  parameter int          MEM_ADDR_WIDTH = 32,
  parameter int          MEM_DATA_WIDTH = 32,
  parameter int unsigned AXI_ID         = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        mem_request_valid,
  output logic                        mem_request_ready,
  input  logic                        mem_request_read_write,
  input  logic [MEM_ADDR_WIDTH-1:0]   mem_request_addr,
  input  logic [MEM_DATA_WIDTH-1:0]   mem_request_data,
  input  logic [MEM_DATA_WIDTH/8-1:0] mem_request_write_enable,
  output logic                        mem_response_valid,
  input  logic                        mem_response_ready,
  output logic [MEM_DATA_WIDTH-1:0]   mem_response_data,
  output logic [MEM_ADDR_WIDTH-1:0]   mem_response_addr,
  output logic                        axi_ar_valid,
  input  logic                        axi_ar_ready,
  output logic [AXI_ID_WIDTH-1:0]     axi_ar_id,
  output logic [AXI_ADDR_WIDTH-1:0]   axi_ar_addr,
  output logic [7:0]                  axi_ar_len,
  output logic [2:0]                  axi_ar_size,
  output logic [1:0]                  axi_ar_burst,
  output logic                        axi_ar_lock,
  output logic [3:0]                  axi_ar_cache,
  output logic [2:0]                  axi_ar_prot,
  output logic [3:0]                  axi_ar_qos,
  output logic [3:0]                  axi_ar_region,
  output logic [AXI_USER_WIDTH-1:0]   axi_ar_user,
  output logic                        axi_aw_valid,
  input  logic                        axi_aw_ready,
  output logic [AXI_ID_WIDTH-1:0]     axi_aw_id,
  output logic [AXI_ADDR_WIDTH-1:0]   axi_aw_addr,
  output logic [7:0]                  axi_aw_len,
  output logic [2:0]                  axi_aw_size,
  output logic [1:0]                  axi_aw_burst,
  output logic                        axi_aw_lock,
  output logic [3:0]                  axi_aw_cache,
  output logic [2:0]                  axi_aw_prot,
  output logic [3:0]                  axi_aw_qos,
  output logic [3:0]                  axi_aw_region,
  output logic [AXI_USER_WIDTH-1:0]   axi_aw_user,
  output logic                        axi_w_valid,
  input  logic                        axi_w_ready,
  output logic [AXI_DATA_WIDTH-1:0]   axi_w_data,
  output logic [AXI_DATA_WIDTH/8-1:0] axi_w_strb,
  output logic                        axi_w_last,
  output logic [AXI_USER_WIDTH-1:0]   axi_w_user,
  input  logic                        axi_r_valid,
  output logic                        axi_r_ready,
  input  logic [AXI_ID_WIDTH-1:0]     axi_r_id,
  input  logic [AXI_DATA_WIDTH-1:0]   axi_r_data,
  input  logic [1:0]                  axi_r_resp,
  input  logic                        axi_r_last,
  input  logic [AXI_USER_WIDTH-1:0]   axi_r_user,
  input  logic                        axi_b_valid,
  output logic                        axi_b_ready,
  input  logic [AXI_ID_WIDTH-1:0]     axi_b_id,
  input  logic [1:0]                  axi_b_resp,
  input  logic [AXI_USER_WIDTH-1:0]   axi_b_user,
  output logic                        error_flag
);

  if (AXI_DATA_WIDTH != MEM_DATA_WIDTH) begin : g_width_check
    $error("axi4_mem_master: AXI_DATA_WIDTH must equal MEM_DATA_WIDTH");
  end

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP} state_t;

  localparam int EXT_W = AXI_ADDR_WIDTH + MEM_ADDR_WIDTH + 2;

  state_t                      state;
  logic                        req_ready;
  logic                        ar_valid, aw_valid, w_valid, r_ready, b_ready, rsp_valid;
  logic [MEM_ADDR_WIDTH-1:0]   addr_q;
  logic [MEM_DATA_WIDTH-1:0]   data_q;
  logic [MEM_DATA_WIDTH/8-1:0] strb_q;
  logic [MEM_DATA_WIDTH-1:0]   rdata_q;
  logic [EXT_W-1:0]            addr_ext;
  logic                        accept, aw_done, w_done;
  logic                        unused_ok;

  assign accept  = (state == IDLE) && mem_request_valid && req_ready;
  // A channel counts as done once its valid has dropped or it handshakes this cycle.
  assign aw_done = !aw_valid || axi_aw_ready;
  assign w_done  = !w_valid || axi_w_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      ar_valid   <= 1'b0;
      aw_valid   <= 1'b0;
      w_valid    <= 1'b0;
      r_ready    <= 1'b0;
      b_ready    <= 1'b0;
      rsp_valid  <= 1'b0;
      error_flag <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            req_ready <= 1'b0;
            if (mem_request_read_write) begin
              aw_valid <= 1'b1;
              w_valid  <= 1'b1;
              state    <= WR_REQ;
            end else begin
              ar_valid <= 1'b1;
              state    <= RD_ADDR;
            end
          end
        end
        RD_ADDR: begin
          if (axi_ar_ready) begin
            ar_valid <= 1'b0;
            r_ready  <= 1'b1;
            state    <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (axi_r_valid) begin
            r_ready    <= 1'b0;
            rsp_valid  <= 1'b1;
            error_flag <= error_flag | (axi_r_resp != 2'b00);
            state      <= RESP;
          end
        end
        RESP: begin
          if (mem_response_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        WR_REQ: begin
          if (aw_valid && axi_aw_ready) aw_valid <= 1'b0;
          if (w_valid && axi_w_ready)   w_valid  <= 1'b0;
          if (aw_done && w_done) begin
            b_ready <= 1'b1;
            state   <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (axi_b_valid) begin
            b_ready    <= 1'b0;
            error_flag <= error_flag | (axi_b_resp != 2'b00);
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q <= mem_request_addr;
      data_q <= mem_request_data;
      strb_q <= mem_request_write_enable;
    end
    if (state == RD_DATA && axi_r_valid) rdata_q <= axi_r_data;
  end

  // Word address scaled to bytes, then zero-extended or truncated to the AXI address width.
  assign addr_ext = {{AXI_ADDR_WIDTH{1'b0}}, addr_q, 2'b00};

  assign mem_request_ready  = req_ready;
  assign mem_response_valid = rsp_valid;
  assign mem_response_data  = rdata_q;
  assign mem_response_addr  = addr_q;

  assign axi_ar_valid  = ar_valid;
  assign axi_ar_id     = AXI_ID_WIDTH'(AXI_ID);
  assign axi_ar_addr   = addr_ext[AXI_ADDR_WIDTH-1:0];
  assign axi_ar_len    = 8'd0;
  assign axi_ar_size   = 3'd2;
  assign axi_ar_burst  = 2'b01;
  assign axi_ar_lock   = 1'b0;
  assign axi_ar_cache  = 4'd0;
  assign axi_ar_prot   = 3'd0;
  assign axi_ar_qos    = 4'd0;
  assign axi_ar_region = 4'd0;
  assign axi_ar_user   = '0;

  assign axi_aw_valid  = aw_valid;
  assign axi_aw_id     = AXI_ID_WIDTH'(AXI_ID);
  assign axi_aw_addr   = addr_ext[AXI_ADDR_WIDTH-1:0];
  assign axi_aw_len    = 8'd0;
  assign axi_aw_size   = 3'd2;
  assign axi_aw_burst  = 2'b01;
  assign axi_aw_lock   = 1'b0;
  assign axi_aw_cache  = 4'd0;
  assign axi_aw_prot   = 3'd0;
  assign axi_aw_qos    = 4'd0;
  assign axi_aw_region = 4'd0;
  assign axi_aw_user   = '0;

  assign axi_w_valid = w_valid;
  assign axi_w_data  = data_q;
  assign axi_w_strb  = strb_q;
  assign axi_w_last  = 1'b1;
  assign axi_w_user  = '0;

  assign axi_r_ready = r_ready;
  assign axi_b_ready = b_ready;

  assign unused_ok = ^{addr_ext[EXT_W-1:AXI_ADDR_WIDTH], axi_r_id, axi_r_last, axi_r_user,
                       axi_b_id, axi_b_user};

endmodule

// File: tb/tb_axi4_mem_master.sv
// Randomized bench for axi4_mem_master: a behavioural AXI slave with random ready/response delays,
// and a word-addressed reference memory that predicts every read result and the sticky error flag.
module tb_axi4_mem_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        mem_request_valid, mem_request_ready, mem_request_read_write;
  logic [31:0] mem_request_addr, mem_request_data;
  logic [3:0]  mem_request_write_enable;
  logic        mem_response_valid, mem_response_ready;
  logic [31:0] mem_response_data, mem_response_addr;
  logic        axi_ar_valid, axi_ar_ready, axi_ar_lock;
  logic [0:0]  axi_ar_id, axi_ar_user;
  logic [31:0] axi_ar_addr;
  logic [7:0]  axi_ar_len;
  logic [2:0]  axi_ar_size, axi_ar_prot;
  logic [1:0]  axi_ar_burst;
  logic [3:0]  axi_ar_cache, axi_ar_qos, axi_ar_region;
  logic        axi_aw_valid, axi_aw_ready, axi_aw_lock;
  logic [0:0]  axi_aw_id, axi_aw_user;
  logic [31:0] axi_aw_addr;
  logic [7:0]  axi_aw_len;
  logic [2:0]  axi_aw_size, axi_aw_prot;
  logic [1:0]  axi_aw_burst;
  logic [3:0]  axi_aw_cache, axi_aw_qos, axi_aw_region;
  logic        axi_w_valid, axi_w_ready, axi_w_last;
  logic [31:0] axi_w_data;
  logic [3:0]  axi_w_strb;
  logic [0:0]  axi_w_user;
  logic        axi_r_valid, axi_r_ready, axi_r_last;
  logic [0:0]  axi_r_id, axi_r_user;
  logic [31:0] axi_r_data;
  logic [1:0]  axi_r_resp;
  logic        axi_b_valid, axi_b_ready;
  logic [0:0]  axi_b_id, axi_b_user;
  logic [1:0]  axi_b_resp;
  logic        error_flag;

  axi4_mem_master dut (
    .clk(clk), .rst(rst),
    .mem_request_valid(mem_request_valid), .mem_request_ready(mem_request_ready),
    .mem_request_read_write(mem_request_read_write), .mem_request_addr(mem_request_addr),
    .mem_request_data(mem_request_data), .mem_request_write_enable(mem_request_write_enable),
    .mem_response_valid(mem_response_valid), .mem_response_ready(mem_response_ready),
    .mem_response_data(mem_response_data), .mem_response_addr(mem_response_addr),
    .axi_ar_valid(axi_ar_valid), .axi_ar_ready(axi_ar_ready), .axi_ar_id(axi_ar_id),
    .axi_ar_addr(axi_ar_addr), .axi_ar_len(axi_ar_len), .axi_ar_size(axi_ar_size),
    .axi_ar_burst(axi_ar_burst), .axi_ar_lock(axi_ar_lock), .axi_ar_cache(axi_ar_cache),
    .axi_ar_prot(axi_ar_prot), .axi_ar_qos(axi_ar_qos), .axi_ar_region(axi_ar_region),
    .axi_ar_user(axi_ar_user),
    .axi_aw_valid(axi_aw_valid), .axi_aw_ready(axi_aw_ready), .axi_aw_id(axi_aw_id),
    .axi_aw_addr(axi_aw_addr), .axi_aw_len(axi_aw_len), .axi_aw_size(axi_aw_size),
    .axi_aw_burst(axi_aw_burst), .axi_aw_lock(axi_aw_lock), .axi_aw_cache(axi_aw_cache),
    .axi_aw_prot(axi_aw_prot), .axi_aw_qos(axi_aw_qos), .axi_aw_region(axi_aw_region),
    .axi_aw_user(axi_aw_user),
    .axi_w_valid(axi_w_valid), .axi_w_ready(axi_w_ready), .axi_w_data(axi_w_data),
    .axi_w_strb(axi_w_strb), .axi_w_last(axi_w_last), .axi_w_user(axi_w_user),
    .axi_r_valid(axi_r_valid), .axi_r_ready(axi_r_ready), .axi_r_id(axi_r_id),
    .axi_r_data(axi_r_data), .axi_r_resp(axi_r_resp), .axi_r_last(axi_r_last),
    .axi_r_user(axi_r_user),
    .axi_b_valid(axi_b_valid), .axi_b_ready(axi_b_ready), .axi_b_id(axi_b_id),
    .axi_b_resp(axi_b_resp), .axi_b_user(axi_b_user),
    .error_flag(error_flag)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dflt(input logic [31:0] b);
    return {b[15:0] ^ 16'h5A5A, ~b[15:0]};
  endfunction

  // Slave knobs (-1 = random delay up to max_dly) and observation counters.
  int ar_dly = -1, aw_dly = -1, w_dly = -1, r_dly = -1, b_dly = -1;
  int max_dly = 3, err_pct = 0;
  int n_ar = 0, n_aw = 0, n_w = 0, n_viol = 0, n_b_early = 0, r_fire_cyc = 0;
  bit err_sent = 0;
  logic [31:0] smem [logic [31:0]];
  logic [31:0] rd_q[$], aw_q[$], wd_q[$], ar_log[$], aw_log[$], wd_log[$];
  logic [3:0]  ws_q[$], ws_log[$];

  function automatic int pick(input int fixed);
    return (fixed >= 0) ? fixed : int'($urandom_range(0, max_dly));
  endfunction

  function automatic logic [31:0] srd(input logic [31:0] a);
    return smem.exists(a) ? smem[a] : dflt(a);
  endfunction

  initial begin
    int ar_cnt, aw_cnt, w_cnt, r_cnt, b_cnt;
    bit ar_fire, aw_fire, w_fire, r_fire, b_fire, pv_ar, pv_aw, pv_w, bad;
    logic [31:0] p_araddr, p_awaddr, p_wdata, a, d, v;
    logic [3:0] p_wstrb, s;
    ar_cnt = -1; aw_cnt = -1; w_cnt = -1; r_cnt = -1; b_cnt = -1;
    {ar_fire, aw_fire, w_fire, r_fire, b_fire, pv_ar, pv_aw, pv_w} = '0;
    p_araddr = 0; p_awaddr = 0; p_wdata = 0; p_wstrb = 0;
    axi_ar_ready = 0; axi_aw_ready = 0; axi_w_ready = 0;
    axi_r_valid = 0; axi_r_data = 0; axi_r_resp = 0; axi_r_id = 0; axi_r_last = 1; axi_r_user = 0;
    axi_b_valid = 0; axi_b_resp = 0; axi_b_id = 0; axi_b_user = 0;
    forever begin
      @(negedge clk); #1;
      if (rst) begin
        axi_ar_ready = 0; axi_aw_ready = 0; axi_w_ready = 0; axi_r_valid = 0; axi_b_valid = 0;
        rd_q.delete(); aw_q.delete(); wd_q.delete(); ws_q.delete();
        ar_cnt = -1; aw_cnt = -1; w_cnt = -1; r_cnt = -1; b_cnt = -1;
        {ar_fire, aw_fire, w_fire, r_fire, b_fire, pv_ar, pv_aw, pv_w} = '0;
        err_sent = 0;
      end else begin
        if (r_fire) axi_r_valid = 0;
        if (b_fire) axi_b_valid = 0;
        if (pv_ar && !ar_fire && (!axi_ar_valid || axi_ar_addr != p_araddr)) n_viol++;
        if (pv_aw && !aw_fire && (!axi_aw_valid || axi_aw_addr != p_awaddr)) n_viol++;
        if (pv_w && !w_fire && (!axi_w_valid || axi_w_data != p_wdata || axi_w_strb != p_wstrb)) n_viol++;
        if (axi_b_ready && (axi_aw_valid || axi_w_valid)) n_b_early++;
        axi_ar_ready = 0; axi_aw_ready = 0; axi_w_ready = 0;
        if (axi_ar_valid) begin
          if (ar_cnt < 0) ar_cnt = pick(ar_dly);
          if (ar_cnt == 0) begin axi_ar_ready = 1; ar_cnt = -1; end else ar_cnt--;
        end
        if (axi_aw_valid) begin
          if (aw_cnt < 0) aw_cnt = pick(aw_dly);
          if (aw_cnt == 0) begin axi_aw_ready = 1; aw_cnt = -1; end else aw_cnt--;
        end
        if (axi_w_valid) begin
          if (w_cnt < 0) w_cnt = pick(w_dly);
          if (w_cnt == 0) begin axi_w_ready = 1; w_cnt = -1; end else w_cnt--;
        end
        if (rd_q.size() > 0 && !axi_r_valid) begin
          if (r_cnt < 0) r_cnt = pick(r_dly);
          if (r_cnt == 0) begin
            a = rd_q.pop_front();
            bad = ($urandom_range(0, 99) < err_pct);
            axi_r_data = srd(a); axi_r_resp = bad ? 2'b10 : 2'b00; err_sent |= bad;
            axi_r_valid = 1; r_cnt = -1;
          end else r_cnt--;
        end
        if (aw_q.size() > 0 && wd_q.size() > 0 && !axi_b_valid) begin
          if (b_cnt < 0) b_cnt = pick(b_dly);
          if (b_cnt == 0) begin
            a = aw_q.pop_front(); d = wd_q.pop_front(); s = ws_q.pop_front();
            v = srd(a);
            for (int i = 0; i < 4; i++) if (s[i]) v[8*i +: 8] = d[8*i +: 8];
            smem[a] = v;
            bad = ($urandom_range(0, 99) < err_pct);
            axi_b_resp = bad ? 2'b10 : 2'b00; err_sent |= bad;
            axi_b_valid = 1; b_cnt = -1;
          end else b_cnt--;
        end
        // Handshakes that will complete at the coming rising edge.
        ar_fire = axi_ar_valid && axi_ar_ready;
        aw_fire = axi_aw_valid && axi_aw_ready;
        w_fire  = axi_w_valid && axi_w_ready;
        r_fire  = axi_r_valid && axi_r_ready;
        b_fire  = axi_b_valid && axi_b_ready;
        if (ar_fire) begin
          rd_q.push_back(axi_ar_addr); ar_log.push_back(axi_ar_addr); n_ar++;
          if (axi_ar_len != 0 || axi_ar_size != 3'd2 || axi_ar_burst != 2'b01 || axi_ar_id != 0 ||
              axi_ar_lock || axi_ar_cache != 0 || axi_ar_prot != 0 || axi_ar_qos != 0 ||
              axi_ar_region != 0) n_viol++;
        end
        if (aw_fire) begin
          aw_q.push_back(axi_aw_addr); aw_log.push_back(axi_aw_addr); n_aw++;
          if (axi_aw_len != 0 || axi_aw_size != 3'd2 || axi_aw_burst != 2'b01 || axi_aw_id != 0 ||
              axi_aw_lock || axi_aw_cache != 0 || axi_aw_prot != 0 || axi_aw_qos != 0 ||
              axi_aw_region != 0) n_viol++;
        end
        if (w_fire) begin
          wd_q.push_back(axi_w_data); ws_q.push_back(axi_w_strb);
          wd_log.push_back(axi_w_data); ws_log.push_back(axi_w_strb); n_w++;
          if (!axi_w_last) n_viol++;
        end
        if (r_fire) r_fire_cyc = cyc + 1;
        pv_ar = axi_ar_valid; p_araddr = axi_ar_addr;
        pv_aw = axi_aw_valid; p_awaddr = axi_aw_addr;
        pv_w = axi_w_valid; p_wdata = axi_w_data; p_wstrb = axi_w_strb;
      end
    end
  end

  // Reference: what a word-addressed memory behind the bridge must hold.
  logic [31:0] mdl [logic [29:0]];

  function automatic logic [31:0] mdl_rd(input logic [31:0] a);
    return mdl.exists(a[29:0]) ? mdl[a[29:0]] : dflt({a[29:0], 2'b00});
  endfunction

  task automatic mdl_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
    logic [31:0] v;
    v = mdl_rd(a);
    for (int i = 0; i < 4; i++) if (we[i]) v[8*i +: 8] = d[8*i +: 8];
    mdl[a[29:0]] = v;
  endtask

  function automatic logic [63:0] pop32(inout logic [31:0] q[$]);
    return (q.size() > 0) ? 64'(q.pop_front()) : 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  task automatic txn(input bit rw, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] we, input int hold);
    int t, n_aw0, n_w0;
    bit busy, saw, moved;
    logic [31:0] exp_d, held, axa;
    axa = {a[29:0], 2'b00};
    n_aw0 = n_aw; n_w0 = n_w;
    mem_request_valid = 1; mem_request_read_write = rw; mem_request_addr = a;
    mem_request_data = d; mem_request_write_enable = we;
    t = 0;
    while (mem_request_ready !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    chk("accept", 64'(t < 20), 64'(1));
    @(negedge clk);
    mem_request_valid = 0; mem_request_addr = $urandom; mem_request_data = $urandom;
    mem_request_write_enable = 4'($urandom);
    if (!rw) begin
      chk("arvalid_lat", 64'(axi_ar_valid), 64'(1));
      exp_d = mdl_rd(a);
      busy = 0; t = 0;
      while (mem_response_valid !== 1'b1 && t < 200) begin
        busy |= mem_request_ready; @(negedge clk); t++;
      end
      chk("rsp_timeout", 64'(t < 200), 64'(1));
      chk("rsp_lat", 64'(cyc), 64'(r_fire_cyc));
      held = mem_response_data; moved = 0;
      for (int i = 0; i < hold; i++) begin
        busy |= mem_request_ready;
        moved |= (mem_response_data !== held) || (mem_response_valid !== 1'b1);
        @(negedge clk);
      end
      chk("rsp_hold", 64'(moved), 64'(0));
      chk("req_ready_busy", 64'(busy | mem_request_ready), 64'(0));
      chk("rd_data", 64'(mem_response_data), 64'(exp_d));
      chk("rsp_addr", 64'(mem_response_addr), 64'(a));
      mem_response_ready = 1; @(negedge clk); mem_response_ready = 0;
      chk("rsp_drop", 64'(mem_response_valid), 64'(0));
      chk("ar_addr", pop32(ar_log), 64'(axa));
    end else begin
      chk("awwvalid_lat", 64'({axi_aw_valid, axi_w_valid}), 64'(2'b11));
      saw = 0; t = 0;
      while (mem_request_ready !== 1'b1 && t < 200) begin
        saw |= mem_response_valid; @(negedge clk); t++;
      end
      chk("wr_done", 64'(t < 200), 64'(1));
      chk("wr_no_rsp", 64'(saw | mem_response_valid), 64'(0));
      chk("aw_beats", 64'(n_aw - n_aw0), 64'(1));
      chk("w_beats", 64'(n_w - n_w0), 64'(1));
      chk("aw_addr", pop32(aw_log), 64'(axa));
      chk("w_data", pop32(wd_log), 64'(d));
      chk("w_strb", (ws_log.size() > 0) ? 64'(ws_log.pop_front()) : 64'hFF, 64'(we));
      mdl_wr(a, d, we);
    end
    chk("error_flag", 64'(error_flag), 64'(err_sent));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    logic [31:0] a;
    rst = 1; mem_request_valid = 0; mem_request_read_write = 0; mem_request_addr = 0;
    mem_request_data = 0; mem_request_write_enable = 0; mem_response_ready = 0;
    repeat (3) @(negedge clk);
    chk("rst_valids", 64'({axi_ar_valid, axi_aw_valid, axi_w_valid, mem_response_valid}), 64'(0));
    chk("rst_readys", 64'({axi_r_ready, axi_b_ready}), 64'(0));
    chk("rst_err", 64'(error_flag), 64'(0));
    chk("rst_req_ready", 64'(mem_request_ready), 64'(1));
    rst = 0;
    @(negedge clk);

    // Directed single read and single write with a zero-wait slave.
    ar_dly = 0; aw_dly = 0; w_dly = 0; r_dly = 0; b_dly = 0;
    smem[32'h100] = 32'hDEAD_BEEF;
    mdl[30'h40]   = 32'hDEAD_BEEF;
    txn(0, 32'h0000_0040, 32'h0, 4'h0, 0);
    txn(1, 32'h0000_0010, 32'h1234_5678, 4'b0011, 0);
    txn(0, 32'h0000_0010, 32'h0, 4'h0, 0);

    // AW accepted three cycles after W, then both together.
    aw_dly = 3; w_dly = 0;
    txn(1, 32'h0000_0011, 32'hCAFE_F00D, 4'b1111, 0);
    aw_dly = 0;
    txn(1, 32'h0000_0012, 32'h0BAD_0BAD, 4'b1000, 0);
    w_dly = 4;
    txn(1, 32'h0000_0013, 32'h5555_AAAA, 4'b0000, 0);
    chk("bready_early", 64'(n_b_early), 64'(0));

    // Address and response backpressure on a read.
    w_dly = 0; ar_dly = 5;
    txn(0, 32'h0000_0011, 32'h0, 4'h0, 4);
    chk("stable_viol", 64'(n_viol), 64'(0));

    // Randomized traffic.
    ar_dly = -1; aw_dly = -1; w_dly = -1; r_dly = -1; b_dly = -1;
    for (int i = 0; i < 80; i++) begin
      a = $urandom & 32'hC000_000F;
      txn(1'($urandom), a, $urandom, 4'($urandom), int'($urandom_range(0, 3)));
    end
    chk("rand_viol", 64'(n_viol), 64'(0));
    chk("rand_bready_early", 64'(n_b_early), 64'(0));

    // Error response: data still returned, flag sticky across OKAY traffic.
    err_pct = 100;
    txn(0, 32'h0000_0040, 32'h0, 4'h0, 1);
    chk("err_set", 64'(error_flag), 64'(1));
    err_pct = 0;
    txn(1, 32'h0000_0005, 32'h0102_0304, 4'b0101, 0);
    txn(0, 32'h0000_0005, 32'h0, 4'h0, 0);
    chk("err_sticky", 64'(error_flag), 64'(1));

    // Reset while waiting for read data.
    r_dly = 10;
    mem_request_valid = 1; mem_request_read_write = 0; mem_request_addr = 32'h7;
    @(negedge clk);
    mem_request_valid = 0;
    t = 0;
    while (axi_r_ready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    chk("reach_rd_data", 64'(t < 50), 64'(1));
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rr_valids", 64'({axi_ar_valid, axi_aw_valid, axi_w_valid, mem_response_valid}), 64'(0));
    chk("rr_readys", 64'({axi_r_ready, axi_b_ready}), 64'(0));
    chk("rr_err_clr", 64'(error_flag), 64'(0));
    @(negedge clk);
    chk("rr_req_ready", 64'(mem_request_ready), 64'(1));
    chk("rr_rresp_idle", 64'(axi_r_ready), 64'(0));
    ar_log.delete(); aw_log.delete(); wd_log.delete(); ws_log.delete();
    r_dly = -1;
    txn(0, 32'h0000_0005, 32'h0, 4'h0, 0);
    txn(0, 32'h0000_0040, 32'h0, 4'h0, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
